// File: rtl/io_port_fl.sv
// Core I/O port block: addressed input registers with new-data flags and an
// interrupt pulse, plus a first-word-fall-through output FIFO to the outside world.
module io_port_fl #(
   parameter  int NBMANT = 16,
   parameter  int NBEXPO = 6,
   parameter  int NUIOIN = 8,
   parameter  int NUIOOU = 8,
   parameter  int FDEPTH = 4,
   localparam int W      = NBMANT + NBEXPO + 1,
   localparam int AIW    = $clog2(NUIOIN),
   localparam int AOW    = $clog2(NUIOOU)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_in,
   input  logic [AIW-1:0] addr_in,
   output logic [W-1:0]   io_in,
   input  logic           out_en,
   input  logic [AOW-1:0] addr_out,
   input  logic [W-1:0]   data_out,
   output logic           itr,
   input  logic           ext_in_valid,
   output logic           ext_in_ready,
   input  logic [AIW-1:0] ext_in_addr,
   input  logic [W-1:0]   ext_in_data,
   output logic           ext_out_valid,
   input  logic           ext_out_ready,
   output logic [AOW-1:0] ext_out_addr,
   output logic [W-1:0]   ext_out_data,
   output logic           ovf
);

   localparam int PW = $clog2(FDEPTH);
   localparam int CW = $clog2(FDEPTH + 1);

   logic [W-1:0]      in_reg [NUIOIN];
   logic [NUIOIN-1:0] new_flag;
   logic              rd_ok;
   logic              wr_ok;
   logic              in_xfer;

   always_comb begin
      rd_ok = 32'(addr_in) < 32'(NUIOIN);
      wr_ok = 32'(ext_in_addr) < 32'(NUIOIN);
      io_in = '0;
      if (rd_ok)
         io_in = in_reg[addr_in];
      // A core read of the same port in this cycle frees the slot for the writer.
      ext_in_ready = !(wr_ok && new_flag[ext_in_addr]) ||
                     (req_in && (addr_in == ext_in_addr));
      in_xfer = ext_in_valid && ext_in_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUIOIN; i++)
            in_reg[i] <= '0;
         new_flag <= '0;
         itr      <= 1'b0;
      end else begin
         itr <= in_xfer;
         if (req_in && rd_ok)
            new_flag[addr_in] <= 1'b0;
         // Ordered after the clear so a same-port write leaves the flag set.
         if (in_xfer && wr_ok) begin
            in_reg[ext_in_addr]   <= ext_in_data;
            new_flag[ext_in_addr] <= 1'b1;
         end
      end
   end

   logic [AOW+W-1:0] mem [FDEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             push;
   logic             pop;

   always_comb begin
      full          = (count == CW'(FDEPTH));
      ext_out_valid = (count != '0);
      pop           = ext_out_valid && ext_out_ready;
      push          = out_en && (!full || pop);
      {ext_out_addr, ext_out_data} = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {addr_out, data_out};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (out_en && full && !pop)
            ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_io_port_fl.sv
// Directed bench for io_port_fl: input registers/flags/interrupt and the output FIFO.
module tb_io_port_fl;

   localparam int W = 23;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_in;
   logic [2:0]   addr_in;
   logic [W-1:0] io_in;
   logic         out_en;
   logic [2:0]   addr_out;
   logic [W-1:0] data_out;
   logic         itr;
   logic         ext_in_valid;
   logic         ext_in_ready;
   logic [2:0]   ext_in_addr;
   logic [W-1:0] ext_in_data;
   logic         ext_out_valid;
   logic         ext_out_ready;
   logic [2:0]   ext_out_addr;
   logic [W-1:0] ext_out_data;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   io_port_fl #(.NBMANT(16), .NBEXPO(6), .NUIOIN(8), .NUIOOU(8), .FDEPTH(4)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
      .out_en(out_en), .addr_out(addr_out), .data_out(data_out), .itr(itr),
      .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
      .ext_in_addr(ext_in_addr), .ext_in_data(ext_in_data),
      .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
      .ext_out_addr(ext_out_addr), .ext_out_data(ext_out_data), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; req_in = 1'b0; addr_in = 3'd0; out_en = 1'b0; addr_out = 3'd0;
      data_out = '0; ext_in_valid = 1'b0; ext_in_addr = 3'd0; ext_in_data = '0;
      ext_out_ready = 1'b0;
      #22;
      total++; if (io_in !== '0) begin bad++; $display("FAIL reset_io_in got=%h exp=0", io_in); end
      total++; if (itr !== 1'b0) begin bad++; $display("FAIL reset_itr got=%b exp=0", itr); end
      total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ext_out_valid); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ext_in_ready); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_basic_read();
      @(negedge clk);
      ext_in_valid = 1'b1; ext_in_addr = 3'd3; ext_in_data = 23'h12345;
      #1;
      total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_first got=%b exp=1", ext_in_ready); end
      @(posedge clk); #1;
      total++; if (itr !== 1'b1) begin bad++; $display("FAIL rd_itr_pulse got=%b exp=1", itr); end
      @(negedge clk);
      ext_in_valid = 1'b0;
      #1;
      total++; if (ext_in_ready !== 1'b0) begin bad++; $display("FAIL rd_unread_held got=%b exp=0", ext_in_ready); end
      req_in = 1'b1; addr_in = 3'd3;
      #1;
      total++; if (io_in !== 23'h12345) begin bad++; $display("FAIL rd_io_in got=%h exp=%h", io_in, 23'h12345); end
      total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_with_req got=%b exp=1", ext_in_ready); end
      @(posedge clk); #1;
      total++; if (itr !== 1'b0) begin bad++; $display("FAIL rd_itr_single got=%b exp=0", itr); end
      @(negedge clk);
      req_in = 1'b0;
      #1;
      total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_after got=%b exp=1", ext_in_ready); end
      total++; if (io_in !== 23'h12345) begin bad++; $display("FAIL rd_reg_kept got=%h exp=%h", io_in, 23'h12345); end
   endtask

   task automatic test_holdoff();
      @(negedge clk);
      ext_in_valid = 1'b1; ext_in_addr = 3'd5; ext_in_data = 23'h0AAAA;
      @(posedge clk);
      @(negedge clk);
      ext_in_data = 23'h0BBBB;
      #1;
      total++; if (ext_in_ready !== 1'b0) begin bad++; $display("FAIL ho_ready_low got=%b exp=0", ext_in_ready); end
      @(posedge clk); #1;
      total++; if (itr !== 1'b0) begin bad++; $display("FAIL ho_no_itr got=%b exp=0", itr); end
      @(negedge clk);
      req_in = 1'b1; addr_in = 3'd5;
      #1;
      total++; if (io_in !== 23'h0AAAA) begin bad++; $display("FAIL ho_old_word got=%h exp=%h", io_in, 23'h0AAAA); end
      total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL ho_ready_req got=%b exp=1", ext_in_ready); end
      @(posedge clk); #1;
      total++; if (itr !== 1'b1) begin bad++; $display("FAIL ho_itr_second got=%b exp=1", itr); end
      @(negedge clk);
      ext_in_valid = 1'b0; req_in = 1'b0;
      #1;
      total++; if (io_in !== 23'h0BBBB) begin bad++; $display("FAIL ho_new_word got=%h exp=%h", io_in, 23'h0BBBB); end
      total++; if (ext_in_ready !== 1'b0) begin bad++; $display("FAIL ho_write_wins got=%b exp=0", ext_in_ready); end
      req_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_in = 1'b0;
      #1;
      total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL ho_ready_free got=%b exp=1", ext_in_ready); end
   endtask

   task automatic test_full_pushpop();
      logic [2:0]   ea [4];
      logic [W-1:0] ed [4];
      ea[0] = 3'd2; ea[1] = 3'd3; ea[2] = 3'd4; ea[3] = 3'd6;
      ed[0] = 23'h201; ed[1] = 23'h202; ed[2] = 23'h203; ed[3] = 23'h2FF;
      ext_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         out_en = 1'b1; addr_out = 3'(i + 1); data_out = W'(32'h200 + i);
         if (i == 0) begin
            #1;
            total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%b exp=0", ext_out_valid); end
         end
         @(posedge clk); #1;
         if (i == 0) begin
            total++; if (ext_out_valid !== 1'b1) begin bad++; $display("FAIL fp_valid_latency got=%b exp=1", ext_out_valid); end
         end
      end
      @(negedge clk);
      total++; if (ext_out_data !== 23'h200) begin bad++; $display("FAIL fp_head_stable got=%h exp=%h", ext_out_data, 23'h200); end
      out_en = 1'b1; addr_out = 3'd6; data_out = 23'h2FF; ext_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_en = 1'b0; ext_out_ready = 1'b0;
      #1;
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fp_ovf_clear got=%b exp=0", ovf); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ext_out_ready = 1'b1;
         #1;
         total++; if (ext_out_valid !== 1'b1) begin bad++; $display("FAIL fp_drain_valid got=%b exp=1", ext_out_valid); end
         total++; if (ext_out_addr !== ea[k]) begin bad++; $display("FAIL fp_drain_addr got=%0d exp=%0d", ext_out_addr, ea[k]); end
         total++; if (ext_out_data !== ed[k]) begin bad++; $display("FAIL fp_drain_data got=%h exp=%h", ext_out_data, ed[k]); end
         @(posedge clk);
      end
      @(negedge clk);
      ext_out_ready = 1'b0;
      #1;
      total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL fp_count4 got=%b exp=0", ext_out_valid); end
   endtask

   task automatic test_overflow();
      ext_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         out_en = 1'b1; addr_out = 3'(i + 1); data_out = W'(32'h100 + i);
         if (i > 0) begin
            total++; if (ext_out_data !== 23'h100) begin bad++; $display("FAIL ov_head_stable got=%h exp=%h", ext_out_data, 23'h100); end
         end
      end
      @(negedge clk);
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ov_before got=%b exp=0", ovf); end
      out_en = 1'b1; addr_out = 3'd7; data_out = 23'h7FFFF;
      @(posedge clk); #1;
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ov_set got=%b exp=1", ovf); end
      @(negedge clk);
      out_en = 1'b0;
      @(posedge clk); #1;
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ov_sticky got=%b exp=1", ovf); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ext_out_ready = 1'b1;
         #1;
         total++; if (ext_out_valid !== 1'b1) begin bad++; $display("FAIL ov_drain_valid got=%b exp=1", ext_out_valid); end
         total++; if (ext_out_addr !== 3'(k + 1)) begin bad++; $display("FAIL ov_drain_addr got=%0d exp=%0d", ext_out_addr, k + 1); end
         total++; if (ext_out_data !== W'(32'h100 + k)) begin bad++; $display("FAIL ov_drain_data got=%h exp=%h", ext_out_data, 32'h100 + k); end
         @(posedge clk);
      end
      @(negedge clk);
      ext_out_ready = 1'b0;
      #1;
      total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL ov_word5_absent got=%b exp=0", ext_out_valid); end
   endtask

   task automatic test_wrap();
      logic [W-1:0] wq [10];
      logic [2:0]   aq [10];
      for (int i = 0; i < 10; i++) begin
         wq[i] = W'($urandom);
         aq[i] = 3'($urandom_range(0, 7));
      end
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         out_en = (i < 10); ext_out_ready = 1'b1;
         if (i < 10) begin
            addr_out = aq[i]; data_out = wq[i];
         end
         #1;
         if (i == 0) begin
            total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL wr_empty got=%b exp=0", ext_out_valid); end
         end else begin
            total++; if (ext_out_valid !== 1'b1) begin bad++; $display("FAIL wr_valid%0d got=%b exp=1", i, ext_out_valid); end
            total++; if (ext_out_addr !== aq[i-1]) begin bad++; $display("FAIL wr_addr%0d got=%0d exp=%0d", i, ext_out_addr, aq[i-1]); end
            total++; if (ext_out_data !== wq[i-1]) begin bad++; $display("FAIL wr_data%0d got=%h exp=%h", i, ext_out_data, wq[i-1]); end
         end
         @(posedge clk);
      end
      @(negedge clk);
      out_en = 1'b0; ext_out_ready = 1'b0;
      #1;
      total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL wr_final_empty got=%b exp=0", ext_out_valid); end
   endtask

   task automatic test_reset_mid();
      ext_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_en = 1'b1; addr_out = 3'd1; data_out = W'(32'h300 + i);
         if (i == 2) begin
            ext_in_valid = 1'b1; ext_in_addr = 3'd2; ext_in_data = 23'h55555;
         end
      end
      @(negedge clk);
      out_en = 1'b0; ext_in_data = 23'h66666;
      addr_in = 3'd2;
      #1;
      total++; if (ext_out_valid !== 1'b1 || itr !== 1'b1 || ovf !== 1'b1 || io_in !== 23'h55555) begin
         bad++; $display("FAIL rm_pre_state got=%b%b%b/%h exp=111/%h", ext_out_valid, itr, ovf, io_in, 23'h55555);
      end
      #1 rst = 1'b1;
      #1;
      total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", ext_out_valid); end
      total++; if (itr !== 1'b0) begin bad++; $display("FAIL rm_itr got=%b exp=0", itr); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rm_ovf got=%b exp=0", ovf); end
      total++; if (io_in !== '0) begin bad++; $display("FAIL rm_io_in got=%h exp=0", io_in); end
      total++; if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL rm_new_clear got=%b exp=1", ext_in_ready); end
      @(posedge clk); #1;
      total++; if (itr !== 1'b0) begin bad++; $display("FAIL rm_itr_held got=%b exp=0", itr); end
      @(negedge clk);
      rst = 1'b0;
      ext_in_valid = 1'b1; ext_in_addr = 3'd1; ext_in_data = 23'h00777;
      out_en = 1'b1; addr_out = 3'd5; data_out = 23'h00999;
      addr_in = 3'd1;
      @(posedge clk); #1;
      total++; if (itr !== 1'b1) begin bad++; $display("FAIL rm_first_itr got=%b exp=1", itr); end
      total++; if (io_in !== 23'h00777) begin bad++; $display("FAIL rm_first_in got=%h exp=%h", io_in, 23'h00777); end
      total++; if (ext_out_valid !== 1'b1) begin bad++; $display("FAIL rm_first_push got=%b exp=1", ext_out_valid); end
      total++; if (ext_out_addr !== 3'd5 || ext_out_data !== 23'h00999) begin
         bad++; $display("FAIL rm_first_head got=%0d/%h exp=5/%h", ext_out_addr, ext_out_data, 23'h00999);
      end
      @(negedge clk);
      ext_in_valid = 1'b0; out_en = 1'b0;
      addr_in = 3'd2;
      #1;
      total++; if (io_in !== '0) begin bad++; $display("FAIL rm_port2_gone got=%h exp=0", io_in); end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_holdoff();
      test_full_pushpop();
      test_overflow();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
